spi_master_param: RTL and testbench

Parametrised successor to the fixed 8-bit, 3-slave, mode-0 SPI master. It supports configurable word width, slave count and SCLK divider, plus all four SPI modes (CPOL/CPHA) selected per transfer. It adds a busy/done handshake toward the host logic and sits between the on-chip controller and the external SPI pins (SCLK, CS, MOSI, MISO).

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_clk_gen.sv | 54 +++++
 rtl/spi_master_param.sv | 181 ++++++++++++++++++
 tb/tb_spi_master_param.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the parametrised SPI master.
// Mode encoding is {CPOL, CPHA}; bit positions are exported for field selects.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider: CLK_DIV-cycle half-periods, registered SCLK, and one-cycle edge strobes
// that fire in the cycle before SCLK toggles so data registers move on the same clk edge.
module spi_clk_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  input  logic stop_i,
  input  logic load_i,
  input  logic load_cpol_i,
  input  logic cpol_i,
  output logic tick_o,
  output logic lead_edge_o,
  output logic trail_edge_o,
  output logic sclk_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             sclk_q, sclk_d;
  logic             wrap;
  logic             sclk_edge;

  always_comb begin
    wrap         = (div_q == DIV_W'(CLK_DIV - 1));
    tick_o       = en_i && wrap;
    sclk_edge    = tick_o && !stop_i;
    // A toggle away from the idle level is a leading edge.
    lead_edge_o  = sclk_edge && (sclk_q == cpol_i);
    trail_edge_o = sclk_edge && (sclk_q != cpol_i);
    div_d        = (!en_i || wrap) ? '0 : div_q + 1'b1;
    sclk_d       = sclk_q;
    if (load_i) begin
      sclk_d = load_cpol_i;
    end else if (sclk_edge) begin
      sclk_d = ~sclk_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o = sclk_q;

endmodule

// File: rtl/spi_master_param.sv
// SPI master, DATA_W bits MSB first, four modes, NUM_SLAVES chip selects; done at cycle
// 1 + CLK_DIV*(2*DATA_W+2) after an accepted start; start is ignored unless IDLE.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_SLAVES = 3,
  parameter int SS_W       = 2,
  parameter int CLK_DIV    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [SS_W-1:0]       slave_select,
  input  logic [1:0]            mode,
  input  logic [DATA_W-1:0]     tx_data,
  output logic [DATA_W-1:0]     rx_data,
  output logic                  busy,
  output logic                  done,
  output logic                  SCLK,
  output logic [NUM_SLAVES-1:0] CS,
  output logic                  MOSI,
  input  logic                  MISO
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  state_e state_q, state_d;

  logic                  accept;
  logic                  clk_en;
  logic                  enter_done;
  logic                  stop;
  logic                  tick;
  logic                  lead_edge;
  logic                  trail_edge;
  logic                  sclk;

  logic [DATA_W-1:0]     tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0]     rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0]     rx_data_q, rx_data_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [NUM_SLAVES-1:0] cs_q, cs_d;
  logic                  mosi_q, mosi_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  cpol_q, cpol_d;
  logic                  cpha_q, cpha_d;

  // Every trailing edge completes one bit, so DATA_W here means all 2*DATA_W edges are out.
  assign stop = (bit_cnt_q == CNT_W'(DATA_W));

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk_i        (clk),
    .reset_i      (reset),
    .en_i         (clk_en),
    .stop_i       (stop),
    .load_i       (accept),
    .load_cpol_i  (mode[CPOL_BIT]),
    .cpol_i       (cpol_q),
    .tick_o       (tick),
    .lead_edge_o  (lead_edge),
    .trail_edge_o (trail_edge),
    .sclk_o       (sclk)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   if (tick) state_d = SHIFT;
      SHIFT:   if (tick && stop) state_d = HOLD;
      HOLD:    if (tick) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The divider also times SETUP, so the first SCLK edge lands on the SETUP->SHIFT boundary.
  always_comb begin
    accept     = (state_q == IDLE) && start && (32'(slave_select) < NUM_SLAVES);
    clk_en     = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);
    enter_done = (state_q == HOLD) && tick;
  end

  always_comb begin
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    bit_cnt_d = bit_cnt_q;
    cs_d      = cs_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;

    if (accept) begin
      tx_sh_d   = tx_data;
      rx_sh_d   = '0;
      bit_cnt_d = '0;
      cs_d      = ~(NUM_SLAVES'(1) << slave_select);
      busy_d    = 1'b1;
      cpol_d    = mode[CPOL_BIT];
      cpha_d    = mode[CPHA_BIT];
      if (!mode[CPHA_BIT]) begin
        mosi_d = tx_data[DATA_W-1];
      end
    end

    if (lead_edge) begin
      if (cpha_q) begin
        mosi_d  = tx_sh_q[DATA_W-1];
        tx_sh_d = tx_sh_q << 1;
      end else begin
        rx_sh_d = {rx_sh_q[DATA_W-2:0], MISO};
      end
    end

    if (trail_edge) begin
      bit_cnt_d = bit_cnt_q + 1'b1;
      if (cpha_q) begin
        rx_sh_d = {rx_sh_q[DATA_W-2:0], MISO};
      end else if (bit_cnt_q != CNT_W'(DATA_W - 1)) begin
        mosi_d  = tx_sh_q[DATA_W-2];
        tx_sh_d = tx_sh_q << 1;
      end
    end

    if (enter_done) begin
      cs_d      = '1;
      busy_d    = 1'b0;
      done_d    = 1'b1;
      rx_data_d = rx_sh_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
      cs_q      <= '1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
    end else begin
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
    end
  end

  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign SCLK    = sclk;
  assign CS      = cs_q;
  assign MOSI    = mosi_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: three parameterisations driven from a vector table, an SPI
// slave model per instance, and a scoreboard of expected words/latency popped on done.
module tb_spi_master_param
  import spi_pkg::*;
;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [2:0]  start_v;
  logic [1:0]  mode_v [3];
  logic [2:0]  sel_v  [3];
  logic [15:0] tx_v   [3];
  logic [2:0]  busy_w, done_w, sclk_w, mosi_w;
  logic [2:0]  miso_r = '0;
  logic [7:0]  rx0, rx1;
  logic [15:0] rx2;
  logic [2:0]  cs0, cs1;
  logic [3:0]  cs2;

  spi_master_param #(.DATA_W(8), .NUM_SLAVES(3), .SS_W(2), .CLK_DIV(1)) dut0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .slave_select(sel_v[0][1:0]),
    .mode(mode_v[0]), .tx_data(tx_v[0][7:0]), .rx_data(rx0), .busy(busy_w[0]),
    .done(done_w[0]), .SCLK(sclk_w[0]), .CS(cs0), .MOSI(mosi_w[0]), .MISO(miso_r[0]));

  spi_master_param #(.DATA_W(8), .NUM_SLAVES(3), .SS_W(2), .CLK_DIV(2)) dut1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .slave_select(sel_v[1][1:0]),
    .mode(mode_v[1]), .tx_data(tx_v[1][7:0]), .rx_data(rx1), .busy(busy_w[1]),
    .done(done_w[1]), .SCLK(sclk_w[1]), .CS(cs1), .MOSI(mosi_w[1]), .MISO(miso_r[1]));

  spi_master_param #(.DATA_W(16), .NUM_SLAVES(4), .SS_W(3), .CLK_DIV(1)) dut2 (
    .clk(clk), .reset(reset), .start(start_v[2]), .slave_select(sel_v[2]),
    .mode(mode_v[2]), .tx_data(tx_v[2]), .rx_data(rx2), .busy(busy_w[2]),
    .done(done_w[2]), .SCLK(sclk_w[2]), .CS(cs2), .MOSI(mosi_w[2]), .MISO(miso_r[2]));

  int n_chk = 0;
  int n_err = 0;

  function automatic int width(input int i);
    return (i == 2) ? 16 : 8;
  endfunction

  function automatic int div(input int i);
    return (i == 1) ? 2 : 1;
  endfunction

  function automatic logic [15:0] get_rx(input int i);
    case (i)
      0:       return {8'h00, rx0};
      1:       return {8'h00, rx1};
      default: return rx2;
    endcase
  endfunction

  function automatic logic [3:0] get_cs(input int i);
    case (i)
      0:       return {1'b0, cs0};
      1:       return {1'b0, cs1};
      default: return cs2;
    endcase
  endfunction

  function automatic logic [3:0] ones_cs(input int i);
    return (i == 2) ? 4'b1111 : 4'b0111;
  endfunction

  function automatic logic cs_act(input int i);
    return get_cs(i) != ones_cs(i);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // SPI slave model: shifts s_word out MSB first, captures MOSI into cap.
  logic [15:0] s_word [3] = '{16'h0, 16'h0, 16'h0};
  logic [1:0]  s_mode [3] = '{2'b00, 2'b00, 2'b00};
  int          s_w    [3] = '{8, 8, 16};
  int          idx    [3] = '{0, 0, 0};
  logic [15:0] cap    [3] = '{16'h0, 16'h0, 16'h0};
  logic [2:0]  cs_prev = '0;
  logic [2:0]  sclk_prev = '0;
  logic        sl_cs, sl_lead;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      sl_cs = cs_act(i);
      if (sl_cs && !cs_prev[i]) begin
        cap[i] = '0;
        idx[i] = s_w[i] - 1;
        if (!s_mode[i][0]) begin
          miso_r[i] = s_word[i][idx[i]];
          idx[i]--;
        end
      end else if (sl_cs && (sclk_w[i] != sclk_prev[i])) begin
        sl_lead = (sclk_w[i] != s_mode[i][1]);
        if (sl_lead ^ s_mode[i][0]) begin
          cap[i] = {cap[i][14:0], mosi_w[i]};
        end else if (idx[i] >= 0) begin
          miso_r[i] = s_word[i][idx[i]];
          idx[i]--;
        end
      end
      cs_prev[i]   = sl_cs;
      sclk_prev[i] = sclk_w[i];
    end
  end

  typedef struct {
    int          inst;
    logic [15:0] rx;
    logic [15:0] mosi;
    int          lat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int          inst;
    logic [1:0]  md;
    logic [2:0]  sel;
    logic [15:0] tx;
    logic [15:0] slv;
    logic        acc;
    logic [3:0]  cse;
  } vec_t;
  vec_t vt [9];

  // Cycle 0 is the cycle start is driven; returns on the done cycle (or at the bound).
  task automatic run(input int i, input logic [1:0] md, input logic [2:0] sl,
                     input logic [15:0] tx, input logic [15:0] sw, input logic acc,
                     input logic [3:0] cse, input logic poke);
    int lat, bcnt, act, k, bound;
    logic seen;
    logic [15:0] msk;
    exp_t e;
    msk   = (width(i) == 16) ? 16'hFFFF : 16'h00FF;
    lat   = 1 + div(i) * (2 * width(i) + 2);
    bound = acc ? lat + 20 : 40;
    @(posedge clk); #1;
    s_mode[i] = md; s_word[i] = sw; s_w[i] = width(i);
    mode_v[i] = md; sel_v[i] = sl; tx_v[i] = tx; start_v[i] = 1'b1;
    check($sformatf("idle_busy_c0[%0d]", i), 32'(busy_w[i]), 32'd0);
    if (acc) sb.push_back('{inst: i, rx: sw & msk, mosi: tx & msk, lat: lat});
    bcnt = 0; act = 0; k = 0; seen = 1'b0;
    while (!seen && k < bound) begin
      @(posedge clk); #1;
      k++;
      start_v[i] = poke && (k == 5 || k == lat);
      if (poke && k == 5) begin
        tx_v[i] = 16'hFFFF; mode_v[i] = MODE3; sel_v[i] = 3'd1;
      end
      bcnt += int'(busy_w[i]);
      act  += int'(busy_w[i] | done_w[i] | cs_act(i));
      if (acc && k == 1) begin
        check($sformatf("busy_c1[%0d]", i), 32'(busy_w[i]), 32'd1);
        check($sformatf("cs_c1[%0d]", i), 32'(get_cs(i)), 32'(cse));
      end
      if (poke && k == 6) check("cs_after_ignored_start", 32'(get_cs(i)), 32'(cse));
      if (acc && done_w[i]) begin
        seen = 1'b1;
        e = sb.pop_front();
        check($sformatf("done_cycle[%0d]", e.inst), 32'(k), 32'(e.lat));
        check($sformatf("rx_data[%0d]", e.inst), 32'(get_rx(i)), 32'(e.rx));
        check($sformatf("mosi_word[%0d]", e.inst), 32'(cap[i] & msk), 32'(e.mosi));
        check($sformatf("busy_cycles[%0d]", e.inst), 32'(bcnt), 32'(e.lat - 1));
        check($sformatf("busy_at_done[%0d]", e.inst), 32'(busy_w[i]), 32'd0);
        check($sformatf("cs_at_done[%0d]", e.inst), 32'(get_cs(i)), 32'(ones_cs(i)));
        check($sformatf("sclk_idle[%0d]", e.inst), 32'(sclk_w[i]), 32'(md[1]));
      end
    end
    if (acc) check($sformatf("done_seen[%0d]", i), 32'(seen), 32'd1);
    else     check($sformatf("no_activity[%0d]", i), 32'(act), 32'd0);
    if (!poke) start_v[i] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int q;
    vt[0] = '{0, MODE0, 3'd0, 16'h00CA, 16'h00B5, 1'b1, 4'b0110};
    vt[1] = '{1, MODE3, 3'd2, 16'h0053, 16'h003C, 1'b1, 4'b0011};
    vt[2] = '{0, MODE1, 3'd1, 16'h00F0, 16'h0022, 1'b1, 4'b0101};
    vt[3] = '{0, MODE2, 3'd1, 16'h00F0, 16'h0022, 1'b1, 4'b0101};
    vt[4] = '{2, MODE0, 3'd3, 16'h1234, 16'hA55A, 1'b1, 4'b0111};
    vt[5] = '{2, MODE2, 3'd5, 16'h1234, 16'hA55A, 1'b0, 4'b1111};
    vt[6] = '{0, MODE0, 3'd3, 16'h00CA, 16'h00B5, 1'b0, 4'b0111};
    vt[7] = '{2, MODE1, 3'd0, 16'h8001, 16'h7FFE, 1'b1, 4'b1110};
    vt[8] = '{1, MODE2, 3'd0, 16'h0081, 16'h007E, 1'b1, 4'b0110};

    reset = 1'b1;
    start_v = '0;
    for (int i = 0; i < 3; i++) begin
      mode_v[i] = 2'b00; sel_v[i] = 3'd0; tx_v[i] = 16'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_rx[%0d]", i), 32'(get_rx(i)), 32'd0);
      check($sformatf("rst_busy[%0d]", i), 32'(busy_w[i]), 32'd0);
      check($sformatf("rst_done[%0d]", i), 32'(done_w[i]), 32'd0);
      check($sformatf("rst_sclk[%0d]", i), 32'(sclk_w[i]), 32'd0);
      check($sformatf("rst_cs[%0d]", i), 32'(get_cs(i)), 32'(ones_cs(i)));
      check($sformatf("rst_mosi[%0d]", i), 32'(mosi_w[i]), 32'd0);
    end
    reset = 1'b0;

    for (int v = 0; v < 9; v++) begin
      run(vt[v].inst, vt[v].md, vt[v].sel, vt[v].tx, vt[v].slv, vt[v].acc, vt[v].cse, 1'b0);
    end

    // Starts at cycle 5 and on the done cycle are ignored; the one right after is taken.
    run(0, MODE0, 3'd0, 16'h00CA, 16'h00B5, 1'b1, 4'b0110, 1'b1);
    run(0, MODE1, 3'd2, 16'h003C, 16'h00C3, 1'b1, 4'b0011, 1'b0);

    // Reset during a mode-2 transfer.
    @(posedge clk); #1;
    s_mode[0] = MODE2; s_word[0] = 16'h005A;
    mode_v[0] = MODE2; sel_v[0] = 3'd1; tx_v[0] = 16'h00A5; start_v[0] = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      if (k == 9) check("busy_before_reset", 32'(busy_w[0]), 32'd1);
      if (k == 10) reset = 1'b1;
    end
    check("rst_mid_cs", 32'(get_cs(0)), 32'(ones_cs(0)));
    check("rst_mid_sclk", 32'(sclk_w[0]), 32'd0);
    check("rst_mid_busy", 32'(busy_w[0]), 32'd0);
    check("rst_mid_rx", 32'(get_rx(0)), 32'd0);
    check("rst_mid_done", 32'(done_w[0]), 32'd0);
    reset = 1'b0;
    q = 0;
    repeat (30) begin
      @(posedge clk); #1;
      q += int'(done_w[0] | busy_w[0]);
    end
    check("rst_quiet", 32'(q), 32'd0);
    run(0, MODE0, 3'd2, 16'h0096, 16'h0069, 1'b1, 4'b0011, 1'b0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
